// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: front-porch/sync/back-porch mode parameters,
// selectable sync polarity, pixel clock-enable, registered outputs and strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 12
) (
  input  logic             pix_clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             vid_active,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SS     = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SE     = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_SS     = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SE     = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t H_FE     = cnt_t'(H_ACTIVE - 1);
  localparam cnt_t V_FE     = cnt_t'(V_ACTIVE - 1);

  generate
    if ((CNT_W < 1) || (CNT_W > 30) ||
        ((H_TOTAL - 1) > ((1 << CNT_W) - 1)) ||
        ((V_TOTAL - 1) > ((1 << CNT_W) - 1))) begin : g_bad_width
      $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if ((H_ACTIVE < 1) || (H_SYNC < 1) || (V_ACTIVE < 1) || (V_SYNC < 1) ||
        (H_FP < 0) || (H_BP < 0) || (V_FP < 0) || (V_BP < 0)) begin : g_bad_mode
      $error("vga_timing_gen: illegal mode parameters");
    end
  endgenerate

  cnt_t h_q, v_q, h_d, v_d;
  cnt_t x_q, y_q;
  logic started_q;
  logic hsync_q, vsync_q, act_q, ls_q, fs_q, fe_q;
  logic hsync_d, vsync_d, act_d;

  // The first enabled edge after reset presents (0,0) instead of advancing.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!started_q) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
    end else begin
      h_d = h_q + cnt_t'(1);
    end
  end

  always_comb begin
    hsync_d = ((h_d >= H_SS) && (h_d < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((v_d >= V_SS) && (v_d < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
    act_d   = (h_d < H_ACT_C) && (v_d < V_ACT_C);
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      started_q <= 1'b0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      act_q     <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else if (en) begin
      h_q       <= h_d;
      v_q       <= v_d;
      x_q       <= act_d ? h_d : '0;
      y_q       <= act_d ? v_d : '0;
      started_q <= 1'b1;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      act_q     <= act_d;
      ls_q      <= (h_d == '0);
      fs_q      <= (h_d == '0) && (v_d == '0);
      fe_q      <= (h_d == H_FE) && (v_d == V_FE);
    end else begin
      // Strobes last exactly one enabled cycle; levels hold while en is low.
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      fe_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vid_active  = act_q;
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in a 14x8 mode, both sync polarities at once.
module tb_vga_timing_gen;

  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic          hs_n, vs_n, act_n, ls_n, fs_n, fe_n;
  logic [CW-1:0] hc_n, vc_n, x_n, y_n;
  logic          hs_p, vs_p, act_p, ls_p, fs_p, fe_p;
  logic [CW-1:0] hc_p, vc_p, x_p, y_p;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW)
  ) u_dut_n (
    .pix_clk(clk), .rst_n(rst_n), .en(en),
    .hsync(hs_n), .vsync(vs_n), .vid_active(act_n),
    .h_count(hc_n), .v_count(vc_n), .x(x_n), .y(y_n),
    .line_start(ls_n), .frame_start(fs_n), .frame_end(fe_n)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(CW)
  ) u_dut_p (
    .pix_clk(clk), .rst_n(rst_n), .en(en),
    .hsync(hs_p), .vsync(vs_p), .vid_active(act_p),
    .h_count(hc_p), .v_count(vc_p), .x(x_p), .y(y_p),
    .line_start(ls_p), .frame_start(fs_p), .frame_end(fe_p)
  );

  typedef struct packed {
    logic          hs_n;
    logic          vs_n;
    logic          hs_p;
    logic          vs_p;
    logic          vid;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
    logic          fe;
  } obs_t;

  obs_t exp_q[$];
  event check_ev;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  int   m_p = 0;
  bit   m_started = 1'b0;
  obs_t m_last;

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs_n = 1'b1;
    o.vs_n = 1'b1;
    return o;
  endfunction

  // 14 pixels per line, 8 lines per frame; linear index p = v*14 + h.
  function automatic obs_t obs_at(int p);
    obs_t o;
    int h, v;
    h = p % 14;
    v = p / 14;
    o = '0;
    o.hs_p = (h >= 10) && (h <= 12);
    o.vs_p = (v >= 5) && (v <= 6);
    o.hs_n = !o.hs_p;
    o.vs_n = !o.vs_p;
    o.vid  = (h < 8) && (v < 4);
    o.hc   = CW'(h);
    o.vc   = CW'(v);
    o.x    = o.vid ? CW'(h) : '0;
    o.y    = o.vid ? CW'(v) : '0;
    o.ls   = (h == 0);
    o.fs   = (p == 0);
    o.fe   = (h == 7) && (v == 3);
    return o;
  endfunction

  function automatic obs_t sample_n();
    obs_t o;
    o.hs_n = hs_n; o.vs_n = vs_n; o.hs_p = hs_p; o.vs_p = vs_p;
    o.vid = act_n; o.hc = hc_n; o.vc = vc_n; o.x = x_n; o.y = y_n;
    o.ls = ls_n; o.fs = fs_n; o.fe = fe_n;
    return o;
  endfunction

  function automatic obs_t sample_p();
    obs_t o;
    o.hs_n = hs_n; o.vs_n = vs_n; o.hs_p = hs_p; o.vs_p = vs_p;
    o.vid = act_p; o.hc = hc_p; o.vc = vc_p; o.x = x_p; o.y = y_p;
    o.ls = ls_p; o.fs = fs_p; o.fe = fe_p;
    return o;
  endfunction

  // Drive one cycle's inputs and queue what the next rising edge must produce.
  task automatic step(input logic e, input logic r);
    @(negedge clk);
    en = e;
    rst_n = r;
    if (!r) begin
      m_started = 1'b0;
      m_p = 0;
      m_last = reset_obs();
    end else if (e) begin
      if (!m_started) begin
        m_p = 0;
        m_started = 1'b1;
      end else begin
        m_p = (m_p + 1) % 112;
      end
      m_last = obs_at(m_p);
    end else begin
      m_last.ls = 1'b0;
      m_last.fs = 1'b0;
      m_last.fe = 1'b0;
    end
    exp_q.push_back(m_last);
  endtask

  initial begin : monitor
    obs_t e, an, ap;
    forever begin
      @(posedge clk or check_ev);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        an = sample_n();
        ap = sample_p();
        txn++;
        checks++;
        if (an !== e) begin
          errors++;
          $display("FAIL txn %0d pol0: got %h required %h", txn, an, e);
        end
        checks++;
        if (ap !== e) begin
          errors++;
          $display("FAIL txn %0d pol1: got %h required %h", txn, ap, e);
        end
        $display("txn %0d rst_n=%0b en=%0b h=%0d v=%0d vid=%0b x=%0d y=%0d hs=%0b/%0b vs=%0b/%0b ls=%0b fs=%0b fe=%0b",
                 txn, rst_n, en, hc_n, vc_n, act_n, x_n, y_n, hs_n, hs_p, vs_n, vs_p,
                 ls_n, fs_n, fe_n);
      end
    end
  end

  initial begin : stimulus
    m_last = reset_obs();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Two full frames plus wrap, free-running.
    for (int i = 0; i < 230; i++) step(1'b1, 1'b1);

    // en toggling 1-0-1 doubles the frame period.
    for (int i = 0; i < 234; i++) step((i % 2) == 0, 1'b1);

    // Advance to h=6, v=2, then assert reset mid-cycle.
    for (int i = 0; i < 120; i++) begin
      if (m_p == 34) break;
      step(1'b1, 1'b1);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_started = 1'b0;
    m_p = 0;
    m_last = reset_obs();
    exp_q.push_back(m_last);
    -> check_ev;

    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
